memory_read_responder: RTL and testbench
========================================

Name: memory_read_responder

Overview:
- Memory-side responder for the single-outstanding read protocol the command-fetch logic drives: address plus level enable in, data plus one-cycle valid out.
- Holds a word array that the bench or host preloads, and returns the addressed word a fixed number of cycles after it accepts a request.
- Sits between the management unit's memory port and main memory. It is the model/controller at the far end of the command-buffer fetch path.

Parameters:
- DEPTH, 256, number of 32-bit words in the array; power of two, minimum 2.
- READ_LATENCY, 3, rising edges from the accept edge to the valid edge; minimum 1.
- ERROR_WORD, 32'hDEAD_BEEF, data returned for an out-of-range address.

Ports:
- aClock  input  1  clock; all logic on the rising edge.
- aReset  input  1  reset; synchronous, active-low (0 = reset).
- aRequestAddr  input  32  byte address of the read; word index = aRequestAddr[31:2], bits [1:0] ignored.
- aRequestEnable  input  1  level request; the initiator holds it high until it has seen valid.
- anOutResponseData  output  32  returned word; stable from the valid edge until the next valid edge.
- anOutResponseValid  output  1  one-cycle pulse; anOutResponseData is valid in that cycle.
- anOutAddressError  output  1  updated with valid; 1 when the word index is >= DEPTH, held with the data.
- anOutBusy  output  1  combinational, equals (state != Idle).
- aLoadEnable  input  1  preload write strobe.
- aLoadAddr  input  32  preload byte address; word index = [31:2]; out-of-range writes are dropped.
- aLoadData  input  32  preload data.

Behaviour:
- Reset, sampled with aReset==0 at a rising edge:
  - state = Idle; anOutResponseData = 0; anOutResponseValid = 0; anOutAddressError = 0; latency counter = 0.
  - Array contents are not cleared.
  - Reset in the middle of a request abandons it; no valid is produced.
- States: Idle, Wait, Release.
- Idle:
  - If aRequestEnable==1 at edge e0, the request is accepted at e0.
  - The word index is captured, the counter is loaded with READ_LATENCY-1, and the state goes to Wait.
  - If enable is high on the first edge after reset is released, the request is accepted on that edge.
- Wait:
  - Counter != 0: decrement.
  - Counter == 0: read the array, or take ERROR_WORD if out of range; register data and the error flag; drive valid to 1; go to Release.
  - The valid edge is therefore e0+READ_LATENCY.
- Release:
  - Valid returns to 0 on the next edge, so it is exactly one cycle wide.
  - Stay in Release until aRequestEnable==0 is sampled, then go to Idle.
  - This stops a level-held enable from being accepted twice.
- Address changes and enable deassertion during Wait are ignored. An accepted request always completes.
- Minimum request-to-request spacing: READ_LATENCY + 2 edges (accept, latency, release observed low).
- Preload write:
  - Synchronous, allowed in any state.
  - On a same-edge collision with the Wait read of the same word, the response returns the OLD value (read-before-write); the new value is visible from the next read.
- anOutResponseData and anOutAddressError change only on the valid edge or on reset.

Decomposition:
- Package memory_responder_pkg:
  - State enum (Idle, Wait, Release).
  - Default ERROR_WORD constant.
  - Function word_index(addr) returning addr[31:2].
- Sub-module memory_word_array:
  - DEPTH x 32 array.
  - One synchronous write port and one combinational read port with read-before-write semantics.
- The responder FSM, counter and output registers live in the top module.

Test Plan (DEPTH=256, READ_LATENCY=3):
- Preload word 4 = 32'h1234_5678; hold enable=1 with addr 32'h10 from edge 10 -> valid=1 only in the cycle after edge 13, data 32'h1234_5678, error 0, busy high from edge 10 until Idle.
- Keep enable high for 5 cycles after valid -> no second valid. Drop enable at edge 20 -> Idle at edge 20, busy low; new request at edge 21 is accepted.
- Request addr 32'h0000_0400 (index 256) -> valid at e0+3, data 32'hDEAD_BEEF, error 1; a preload to the same address leaves the array unchanged.
- Word 7 = 32'hAAAA_0000; request addr 32'h1C; preload word 7 = 32'h5555_FFFF on the Wait read edge -> response 32'hAAAA_0000; the following read returns 32'h5555_FFFF.
- Assert aReset=0 at e0+1 during Wait -> no valid ever appears, outputs 0, Idle; array word 4 still 32'h1234_5678 on the next read.
- READ_LATENCY=1 build, addr 32'h0 with word 0 = 32'h0000_0001 -> valid on edge e0+1, data 32'h0000_0001.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// Shared types and helpers for the memory read responder.
// Holds the FSM state type, the default error word and the byte-to-word address helper.
package memory_responder_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StRelease = 2'd2
  } state_e;

  localparam logic [31:0] DefaultErrorWord = 32'hDEAD_BEEF;

  localparam int unsigned WordIdxW = 30;

  // Byte address to word index; the two byte-lane bits are ignored.
  function automatic logic [WordIdxW-1:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/memory_word_array.sv
// Depth x 32 word store with one synchronous write port and one combinational read port.
// A read and a write to the same word on the same edge return the old value.
module memory_word_array #(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/memory_read_responder.sv
// Memory-side responder for the single-outstanding read protocol: accepts a level-held request,
// returns the addressed word READ_LATENCY edges later with a one-cycle valid pulse.
module memory_read_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned READ_LATENCY = 3,
  parameter logic [31:0] ERROR_WORD   = DefaultErrorWord
) (
  input  logic        aClock,
  input  logic        aReset,
  input  logic [31:0] aRequestAddr,
  input  logic        aRequestEnable,
  output logic [31:0] anOutResponseData,
  output logic        anOutResponseValid,
  output logic        anOutAddressError,
  output logic        anOutBusy,
  input  logic        aLoadEnable,
  input  logic [31:0] aLoadAddr,
  input  logic [31:0] aLoadData
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CntW-1:0]     CntLoad  = CntW'(READ_LATENCY - 1);
  localparam logic [WordIdxW-1:0] DepthIdx = WordIdxW'(DEPTH);

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [WordIdxW-1:0] idx_q;
  logic [31:0]         data_q;
  logic                valid_q;
  logic                err_q;

  logic [WordIdxW-1:0] load_idx;
  logic                load_in_range;
  logic                load_we;
  logic                rd_in_range;
  logic [31:0]         arr_rdata;

  assign load_idx      = word_index(aLoadAddr);
  assign load_in_range = (load_idx < DepthIdx);
  // Out-of-range preloads are dropped rather than aliased onto a low word.
  assign load_we       = aLoadEnable && load_in_range;
  assign rd_in_range   = (idx_q < DepthIdx);

  memory_word_array #(
    .Depth(DEPTH),
    .AddrW(AddrW)
  ) u_array (
    .clk_i  (aClock),
    .we_i   (load_we),
    .waddr_i(load_idx[AddrW-1:0]),
    .wdata_i(aLoadData),
    .raddr_i(idx_q[AddrW-1:0]),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge aClock) begin
    if (!aReset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (aRequestEnable) begin
            idx_q   <= word_index(aRequestAddr);
            cnt_q   <= CntLoad;
            state_q <= StWait;
          end
        end
        StWait: begin
          // Address and enable are ignored here; an accepted request always completes.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            data_q  <= rd_in_range ? arr_rdata : ERROR_WORD;
            err_q   <= !rd_in_range;
            valid_q <= 1'b1;
            state_q <= StRelease;
          end
        end
        StRelease: begin
          // Wait for the initiator to drop its level request so it is not accepted twice.
          if (!aRequestEnable) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign anOutResponseData  = data_q;
  assign anOutResponseValid = valid_q;
  assign anOutAddressError  = err_q;
  assign anOutBusy          = (state_q != StIdle);

endmodule

// File: tb/tb_memory_read_responder.sv
// Self-checking bench for memory_read_responder: table vectors, directed corner sequences and
// randomized reads with interleaved preloads checked against an array-plus-timing model.
module tb_memory_read_responder;

  localparam int unsigned Depth = 256;
  localparam int unsigned Lat   = 3;
  localparam logic [31:0] ErrWord = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] req_addr = '0, ld_addr = '0, ld_data = '0;
  logic        req_en = 1'b0, ld_en = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_valid, rsp_err, busy;

  logic [31:0] r1_addr = '0, r1_ld_addr = '0, r1_ld_data = '0;
  logic        r1_en = 1'b0, r1_ld_en = 1'b0;
  logic [31:0] r1_data;
  logic        r1_valid, r1_err, r1_busy;

  memory_read_responder #(
    .DEPTH(Depth),
    .READ_LATENCY(Lat),
    .ERROR_WORD(ErrWord)
  ) dut (
    .aClock            (clk),
    .aReset            (rst_n),
    .aRequestAddr      (req_addr),
    .aRequestEnable    (req_en),
    .anOutResponseData (rsp_data),
    .anOutResponseValid(rsp_valid),
    .anOutAddressError (rsp_err),
    .anOutBusy         (busy),
    .aLoadEnable       (ld_en),
    .aLoadAddr         (ld_addr),
    .aLoadData         (ld_data)
  );

  memory_read_responder #(
    .DEPTH(Depth),
    .READ_LATENCY(1),
    .ERROR_WORD(ErrWord)
  ) dut_l1 (
    .aClock            (clk),
    .aReset            (rst_n),
    .aRequestAddr      (r1_addr),
    .aRequestEnable    (r1_en),
    .anOutResponseData (r1_data),
    .anOutResponseValid(r1_valid),
    .anOutAddressError (r1_err),
    .anOutBusy         (r1_busy),
    .aLoadEnable       (r1_ld_en),
    .aLoadAddr         (r1_ld_addr),
    .aLoadData         (r1_ld_data)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [Depth];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;
  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    logic [29:0] idx;
    idx = a[31:2];
    return idx < 30'(Depth);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (in_range(a)) return model[a[9:2]];
    return ErrWord;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (in_range(a)) model[a[9:2]] = d;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
    model_write(a, d);
  endtask

  // lmode: 0 no loads, 1 random loads/inputs during the wait, 2 given load on the valid edge.
  task automatic do_read(input logic [31:0] addr, input int hold, input int lmode,
                         input logic [31:0] la, input logic [31:0] ldv,
                         output logic [31:0] got_d, output logic got_e);
    logic [31:0] exp_d;
    logic        exp_e;
    exp_d = '0;
    exp_e = !in_range(addr);
    req_en = 1'b1;
    req_addr = addr;
    ld_en = 1'b0;
    tick();
    check("accept_busy", busy, 1);
    check("accept_novalid", rsp_valid, 0);
    for (int k = 1; k <= Lat; k++) begin
      if (lmode == 1) begin
        req_en = 1'($urandom_range(0, 1));
        req_addr = $urandom;
        ld_en = 1'($urandom_range(0, 1));
        ld_data = $urandom;
        case ($urandom_range(0, 3))
          0: ld_addr = addr;
          1: ld_addr = $urandom | 32'h400;
          default: ld_addr = 32'($urandom_range(0, 1023));
        endcase
      end else if (lmode == 2 && k == Lat) begin
        ld_en = 1'b1;
        ld_addr = la;
        ld_data = ldv;
      end
      exp_d = model_read(addr);
      tick();
      if (ld_en) model_write(ld_addr, ld_data);
      ld_en = 1'b0;
      if (k < Lat) begin
        check("wait_novalid", rsp_valid, 0);
        check("wait_busy", busy, 1);
      end else begin
        check("valid_edge", rsp_valid, 1);
        check("rsp_data", rsp_data, exp_d);
        check("rsp_err", rsp_err, exp_e);
        check("valid_busy", busy, 1);
      end
    end
    got_d = rsp_data;
    got_e = rsp_err;
    for (int h = 0; h < hold; h++) begin
      req_en = 1'b1;
      tick();
      check("hold_novalid", rsp_valid, 0);
      check("hold_busy", busy, 1);
      check("hold_data", rsp_data, exp_d);
    end
    req_en = 1'b0;
    tick();
    check("idle_novalid", rsp_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_data", rsp_data, exp_d);
    check("idle_err", rsp_err, exp_e);
  endtask

  initial begin
    logic [31:0] gd;
    logic        ge;
    logic [31:0] ra;

    vecs[0] = '{32'h0000_0000, 32'hC0DE_0000, 1'b0};
    vecs[1] = '{32'h0000_0010, 32'hC0DE_0004, 1'b0};
    vecs[2] = '{32'h0000_0013, 32'hC0DE_0004, 1'b0};
    vecs[3] = '{32'h0000_03FC, 32'hC0DE_00FF, 1'b0};
    vecs[4] = '{32'h0000_03FF, 32'hC0DE_00FF, 1'b0};
    vecs[5] = '{32'h0000_0400, 32'hDEAD_BEEF, 1'b1};
    vecs[6] = '{32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1};
    vecs[7] = '{32'h0000_001C, 32'hC0DE_0007, 1'b0};

    rst_n = 1'b0;
    tick();
    tick();
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_l1_busy", r1_busy, 0);
    rst_n = 1'b1;

    for (int i = 0; i < int'(Depth); i++) preload(32'(i * 4), 32'hC0DE_0000 | 32'(i));

    for (int i = 0; i < 8; i++) begin
      do_read(vecs[i].addr, i % 3, 0, '0, '0, gd, ge);
      check("vec_data", gd, vecs[i].data);
      check("vec_err", 32'(ge), 32'(vecs[i].err));
    end

    // Level-held enable for five cycles after valid must not retrigger.
    preload(32'h10, 32'h1234_5678);
    do_read(32'h10, 5, 0, '0, '0, gd, ge);
    check("word4_data", gd, 32'h1234_5678);

    do_read(32'h400, 0, 0, '0, '0, gd, ge);
    check("oor_data", gd, 32'hDEAD_BEEF);
    check("oor_err", 32'(ge), 1);
    preload(32'h400, 32'hBAD0_BAD0);
    do_read(32'h0, 0, 0, '0, '0, gd, ge);
    check("oor_preload_dropped", gd, 32'hC0DE_0000);

    preload(32'h1C, 32'hAAAA_0000);
    do_read(32'h1C, 1, 2, 32'h1C, 32'h5555_FFFF, gd, ge);
    check("collision_old", gd, 32'hAAAA_0000);
    do_read(32'h1C, 0, 0, '0, '0, gd, ge);
    check("collision_new", gd, 32'h5555_FFFF);

    // Reset one edge after accept abandons the request.
    req_en = 1'b1;
    req_addr = 32'h10;
    tick();
    check("mid_accept_busy", busy, 1);
    rst_n = 1'b0;
    req_en = 1'b0;
    tick();
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_data", rsp_data, 0);
    check("mid_rst_err", rsp_err, 0);
    check("mid_rst_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_hold_novalid", rsp_valid, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_novalid", rsp_valid, 0);
      check("post_rst_idle", busy, 0);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    do_read(32'h10, 0, 0, '0, '0, gd, ge);
    check("array_kept_over_reset", gd, 32'h1234_5678);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) ra = $urandom | 32'h400;
      else ra = 32'($urandom_range(0, 1023));
      do_read(ra, int'($urandom_range(0, 3)), 1, '0, '0, gd, ge);
    end

    r1_ld_en = 1'b1;
    r1_ld_addr = 32'h0;
    r1_ld_data = 32'h0000_0001;
    tick();
    r1_ld_en = 1'b0;
    r1_en = 1'b1;
    r1_addr = 32'h0;
    tick();
    check("l1_accept_busy", r1_busy, 1);
    check("l1_accept_novalid", r1_valid, 0);
    tick();
    check("l1_valid", r1_valid, 1);
    check("l1_data", r1_data, 32'h0000_0001);
    check("l1_err", r1_err, 0);
    r1_en = 1'b0;
    tick();
    check("l1_release_novalid", r1_valid, 0);
    check("l1_idle", r1_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
